// File: rtl/queue_reader_pkg.sv
// Shared definitions for the Hough line-candidate queue drain path.
package queue_reader_pkg;

    // Field widths shared with the candidate queue.
    localparam int unsigned RMsb     = 11;
    localparam int unsigned PhiMsb   = 7;
    localparam int unsigned LinesMsb = 2;

    // Default lane-plausible angle window, both bounds inclusive.
    localparam logic [PhiMsb:0] PhiLoDefault = 8'd20;
    localparam logic [PhiMsb:0] PhiHiDefault = 8'd160;

    localparam int unsigned MaxLinesDefault = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StPop   = 3'd2,
        StOut   = 3'd3,
        StFlush = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Saturating 8-bit increment for event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/phi_window.sv
// Combinational inclusive range check on an unsigned angle.
module phi_window #(
    parameter int unsigned      Width = 8,
    parameter logic [Width-1:0] Lo    = '0,
    parameter logic [Width-1:0] Hi    = '1
) (
    input  logic [Width-1:0] phi_i,
    output logic             in_range_o
);

    assign in_range_o = (phi_i >= Lo) && (phi_i <= Hi);

endmodule

// File: rtl/queue_reader.sv
// Drains the line-candidate queue, forwards in-window lines, flushes the rest.
module queue_reader
    import queue_reader_pkg::*;
#(
    parameter int unsigned      msb_r     = RMsb,
    parameter int unsigned      msb_phi   = PhiMsb,
    parameter logic [msb_phi:0] phi_lo    = PhiLoDefault,
    parameter logic [msb_phi:0] phi_hi    = PhiHiDefault,
    parameter int unsigned      max_lines = MaxLinesDefault,
    parameter int unsigned      msb_lines = LinesMsb
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               queue_empty,
    input  logic [msb_r:0]     r_in,
    input  logic [msb_phi:0]   phi_in,
    output logic               q_pop,
    output logic               line_valid,
    input  logic               line_ready,
    output logic [msb_r:0]     r_out,
    output logic [msb_phi:0]   phi_out,
    output logic [msb_lines:0] line_cnt,
    output logic [7:0]         drop_cnt,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [msb_lines:0] LineLimit = max_lines[msb_lines:0];

    state_e             state_q;
    logic [msb_r:0]     r_q;
    logic [msb_phi:0]   phi_q;
    logic [msb_lines:0] line_cnt_q;
    logic [msb_lines:0] line_cnt_inc;
    logic [7:0]         drop_cnt_q;
    logic               fe_seen_q;
    logic               line_valid_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               in_win;

    phi_window #(
        .Width (msb_phi + 1),
        .Lo    (phi_lo),
        .Hi    (phi_hi)
    ) u_phi_window (
        .phi_i      (phi_q),
        .in_range_o (in_win)
    );

    assign line_cnt_inc = line_cnt_q + 1'b1;

    // Pop must track queue_empty in the same cycle, so it is decoded rather than registered.
    assign q_pop = (state_q == StPop) | ((state_q == StFlush) & ~queue_empty);

    assign line_valid = line_valid_q;
    assign r_out      = r_q;
    assign phi_out    = phi_q;
    assign line_cnt   = line_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Frame FSM with capture registers, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            r_q          <= '0;
            phi_q        <= '0;
            line_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            fe_seen_q    <= 1'b0;
            line_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if ((state_q != StIdle) && frame_end) begin
                fe_seen_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_q    <= StLoad;
                        line_cnt_q <= '0;
                        drop_cnt_q <= '0;
                        // A coincident frame_end belongs to the frame being started.
                        fe_seen_q  <= frame_end;
                        busy_q     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (!queue_empty) begin
                        r_q     <= r_in;
                        phi_q   <= phi_in;
                        state_q <= StPop;
                    end else if (fe_seen_q || frame_end) begin
                        state_q      <= StDone;
                        frame_done_q <= 1'b1;
                    end
                end
                StPop: begin
                    if (in_win) begin
                        state_q      <= StOut;
                        line_valid_q <= 1'b1;
                    end else begin
                        drop_cnt_q <= sat_inc8(drop_cnt_q);
                        state_q    <= StLoad;
                    end
                end
                StOut: begin
                    if (line_ready) begin
                        line_valid_q <= 1'b0;
                        line_cnt_q   <= line_cnt_inc;
                        state_q      <= (line_cnt_inc == LineLimit) ? StFlush : StLoad;
                    end
                end
                StFlush: begin
                    if (!queue_empty) begin
                        drop_cnt_q <= sat_inc8(drop_cnt_q);
                    end else if (fe_seen_q) begin
                        state_q      <= StDone;
                        frame_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
